// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit for the execute stage

module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            flush,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;     // multiply: {partial product, remaining multiplier}
  logic [XLEN-1:0]   rem_q, rem_d;     // divide: partial remainder
  logic [XLEN-1:0]   quo_q, quo_d;     // divide: dividend shifting out, quotient shifting in
  logic [XLEN-1:0]   b_q, b_d;         // multiplicand / divisor magnitude
  logic              neg_q, neg_d;     // negate the magnitude result at the end
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Operand preparation on the accept cycle
  logic              a_signed, b_signed, sa, sb;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   special_res;

  assign a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  assign b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign sa       = a_signed & in_a[XLEN-1];
  assign sb       = b_signed & in_b[XLEN-1];
  assign a_mag    = sa ? -in_a : in_a;
  assign b_mag    = sb ? -in_b : in_b;
  assign div_zero = op[2] && (in_b == '0);
  assign div_ovf  = ((op == OP_DIV) || (op == OP_REM)) &&
                    (in_a == {1'b1, {(XLEN-1){1'b0}}}) && (in_b == {XLEN{1'b1}});
  // REM/REMU have op[1] set; divide-by-zero returns the dividend, overflow returns zero
  assign special_res = op[1] ? (div_zero ? in_a : '0)
                             : (div_zero ? {XLEN{1'b1}} : {1'b1, {(XLEN-1){1'b0}}});

  // One radix-2 step of each datapath
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nx;
  logic [XLEN:0]     rem_sh, rem_diff;
  logic              q_bit;
  logic [XLEN-1:0]   rem_nx, quo_nx;

  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? b_q : {XLEN{1'b0}})};
  assign mul_nx   = {mul_sum, acc_q[XLEN-1:1]};
  assign rem_sh   = {rem_q, quo_q[XLEN-1]};
  assign rem_diff = rem_sh - {1'b0, b_q};
  assign q_bit    = ~rem_diff[XLEN];
  assign rem_nx   = q_bit ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
  assign quo_nx   = {quo_q[XLEN-2:0], q_bit};

  // Sign fix and word select, applied to the final iteration's values
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, final_res;

  assign prod_fix  = neg_q ? -mul_nx : mul_nx;
  assign quo_fix   = neg_q ? -quo_nx : quo_nx;
  assign rem_fix   = neg_q ? -rem_nx : rem_nx;
  assign final_res = op_q[2] ? (op_q[1] ? rem_fix : quo_fix)
                             : ((op_q == OP_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN]);

  // Next-state logic: accept, iterate, finish; flush always returns to idle
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    b_d      = b_q;
    neg_d    = neg_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          op_d  = op;
          b_d   = b_mag;
          neg_d = (op[2] && op[1]) ? sa : (sa ^ sb);
          cnt_d = '0;
          acc_d = {{XLEN{1'b0}}, a_mag};
          rem_d = '0;
          quo_d = a_mag;
          if (div_zero || div_ovf) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = special_res;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = mul_nx;
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'(XLEN-1)) begin
            state_d  = S_DONE;
            done_d   = 1'b1;
            result_d = final_res;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      b_q      <= '0;
      neg_q    <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      b_q      <= b_d;
      neg_q    <= neg_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign ready  = (state_q == S_IDLE);
  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard testbench for muldiv_unit

module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op_i = 3'b000;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;
  logic        flush = 1'b0;
  logic        ready, busy, done;
  logic [31:0] result;

  int passed = 0;
  int total = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_res = '0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op_i), .in_a(a_i), .in_b(b_i),
    .flush(flush), .ready(ready), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Waits for ready, issues one op (start in cycle 0), returns the cycle done rose in (-1 on timeout)
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] expv, output int dc);
    int w;
    w = 0;
    while (!ready && w < 100) begin
      cyc();
      w++;
    end
    exp_q.push_back(expv);
    start = 1'b1; op_i = op; a_i = a; b_i = b;
    cyc();
    start = 1'b0;
    dc = -1;
    for (int c = 1; c <= 60; c++) begin
      if (done) begin
        dc = c;
        break;
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0;
    total++; if ({ready, busy, done} !== 3'b100) $display("FAIL reset_flags got %b exp 100", {ready, busy, done}); else passed++;
    total++; if (result !== 32'h0) $display("FAIL reset_result got %h exp 00000000", result); else passed++;
  endtask

  task automatic test_mul_timing();
    logic [31:0] e;
    logic [2:0] ef;
    exp_q.push_back(32'h0000002A);
    start = 1'b1; op_i = 3'b000; a_i = 32'd7; b_i = 32'd6;
    cyc();
    start = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      ef = {c == 34, c <= 33, c == 33};
      total++; if ({ready, busy, done} !== ef) $display("FAIL mul_timing cycle %0d got %b exp %b", c, {ready, busy, done}, ef); else passed++;
      if (c == 33) begin
        e = exp_q.pop_front();
        last_res = e;
        total++; if (result !== e) $display("FAIL mul_result got %h exp %h", result, e); else passed++;
      end
      cyc();
    end
  endtask

  task automatic test_table(input string name, input int n, input logic [2:0] ops[8],
                            input logic [31:0] as[8], input logic [31:0] bs[8],
                            input logic [31:0] es[8], input int exp_dc);
    int dc;
    logic [31:0] e;
    for (int i = 0; i < n; i++) begin
      do_op(ops[i], as[i], bs[i], es[i], dc);
      e = exp_q.pop_front();
      last_res = e;
      total++; if (result !== e) $display("FAIL %s_%0d result got %h exp %h", name, i, result, e); else passed++;
      total++; if (dc !== exp_dc) $display("FAIL %s_%0d done_cycle got %0d exp %0d", name, i, dc, exp_dc); else passed++;
      cyc();
    end
  endtask

  task automatic test_mulh();
    logic [2:0]  ops[8] = '{3'b001, 3'b011, 3'b010, 3'b000, 0, 0, 0, 0};
    logic [31:0] as[8]  = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 0, 0, 0, 0};
    logic [31:0] bs[8]  = '{32'h3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h3, 0, 0, 0, 0};
    logic [31:0] es[8]  = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFA, 0, 0, 0, 0};
    test_table("mulh", 4, ops, as, bs, es, 33);
  endtask

  task automatic test_div();
    logic [2:0]  ops[8] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b101, 0, 0, 0};
    logic [31:0] as[8]  = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd1000, 0, 0, 0};
    logic [31:0] bs[8]  = '{32'd2, 32'd2, 32'd2, 32'd2, 32'd7, 0, 0, 0};
    logic [31:0] es[8]  = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h7FFFFFFC, 32'h1, 32'd142, 0, 0, 0};
    test_table("div", 5, ops, as, bs, es, 33);
  endtask

  task automatic test_special();
    logic [2:0]  ops[8] = '{3'b100, 3'b111, 3'b100, 3'b110, 3'b101, 3'b110, 0, 0};
    logic [31:0] as[8]  = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'd9, 32'hFFFFFFF9, 0, 0};
    logic [31:0] bs[8]  = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0, 0, 0};
    logic [31:0] es[8]  = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFF9, 0, 0};
    test_table("special", 6, ops, as, bs, es, 1);
  endtask

  task automatic test_flush();
    int dcount;
    start = 1'b1; flush = 1'b1; op_i = 3'b000; a_i = 32'd3; b_i = 32'd3;
    cyc();
    start = 1'b0; flush = 1'b0;
    total++; if ({ready, busy} !== 2'b10) $display("FAIL flush_idle got %b exp 10", {ready, busy}); else passed++;
    start = 1'b1; op_i = 3'b101; a_i = 32'd100; b_i = 32'd7;
    cyc();
    start = 1'b0;
    for (int c = 1; c < 10; c++) cyc();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    total++; if ({ready, busy, done} !== 3'b100) $display("FAIL flush_calc got %b exp 100", {ready, busy, done}); else passed++;
    dcount = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) dcount++;
      cyc();
    end
    total++; if (dcount !== 0) $display("FAIL flush_no_done got %0d exp 0", dcount); else passed++;
    total++; if (result !== last_res) $display("FAIL flush_result got %h exp %h", result, last_res); else passed++;
  endtask

  task automatic test_ignored_start();
    int dc;
    logic [31:0] e;
    exp_q.push_back(32'd333);
    start = 1'b1; op_i = 3'b101; a_i = 32'd1000; b_i = 32'd3;
    cyc();
    start = 1'b0;
    for (int c = 1; c < 5; c++) cyc();
    start = 1'b1; op_i = 3'b000; a_i = 32'd2; b_i = 32'd2;
    cyc();
    start = 1'b0;
    dc = -1;
    for (int c = 6; c <= 60; c++) begin
      if (done) begin
        dc = c;
        break;
      end
      cyc();
    end
    e = exp_q.pop_front();
    last_res = e;
    total++; if (result !== e) $display("FAIL ignored_start result got %h exp %h", result, e); else passed++;
    total++; if (dc !== 33) $display("FAIL ignored_start done_cycle got %0d exp 33", dc); else passed++;
    cyc();
    total++; if ({ready, busy} !== 2'b10) $display("FAIL ignored_start_after got %b exp 10", {ready, busy}); else passed++;
  endtask

  task automatic test_reset_mid();
    int dcount;
    start = 1'b1; op_i = 3'b000; a_i = 32'd5; b_i = 32'd5;
    cyc();
    start = 1'b0;
    for (int c = 1; c < 20; c++) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    last_res = 32'h0;
    total++; if ({ready, busy, done} !== 3'b100) $display("FAIL reset_mid_flags got %b exp 100", {ready, busy, done}); else passed++;
    total++; if (result !== 32'h0) $display("FAIL reset_mid_result got %h exp 00000000", result); else passed++;
    dcount = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) dcount++;
      cyc();
    end
    total++; if (dcount !== 0) $display("FAIL reset_mid_no_done got %0d exp 0", dcount); else passed++;
  endtask

  task automatic test_back_to_back();
    int dc;
    logic [31:0] e;
    do_op(3'b000, 32'd123, 32'd456, 32'd56088, dc);
    e = exp_q.pop_front();
    total++; if (result !== e || dc !== 33) $display("FAIL b2b_first got %h/%0d exp %h/33", result, dc, e); else passed++;
    cyc();
    total++; if (ready !== 1'b1) $display("FAIL b2b_ready got %b exp 1", ready); else passed++;
    do_op(3'b100, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, dc);
    e = exp_q.pop_front();
    total++; if (result !== e || dc !== 33) $display("FAIL b2b_second got %h/%0d exp %h/33", result, dc, e); else passed++;
    cyc();
    do_op(3'b110, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, dc);
    e = exp_q.pop_front();
    last_res = e;
    total++; if (result !== e || dc !== 33) $display("FAIL b2b_third got %h/%0d exp %h/33", result, dc, e); else passed++;
    cyc();
  endtask

  initial begin
    test_reset();
    test_mul_timing();
    test_mulh();
    test_div();
    test_special();
    test_flush();
    test_ignored_start();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
